// File: rtl/mfp_fifo_pkg.sv
// Shared constants and types for the RAM-backed FWFT FIFO controller.
// The MFP_FIFO_LEVEL_EN build option uses count_width() to size the level port.
package mfp_fifo_pkg;

   localparam int PREFETCH_DEPTH = 2;

   // Prefetch buffer occupancy, 0..PREFETCH_DEPTH
   typedef logic [$clog2(PREFETCH_DEPTH+1)-1:0] buf_count_t;

   function automatic int count_width(input int addr_width);
      return addr_width + 2;
   endfunction

endpackage

// File: rtl/mfp_dual_port_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read
// that returns the old word when reading the address being written.
module mfp_dual_port_ram #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
)
(
   input  logic                  clk,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] read_data
);

   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (write_enable) mem[write_addr] <= write_data;
      read_data <= mem[read_addr];
   end

endmodule

// File: rtl/mfp_fifo_prefetch_buf.sv
// Two-entry in-order skid buffer that holds words read back from the FIFO RAM.
// Entry 0 is always the head; entry 1 only holds a word while the count is two.
module mfp_fifo_prefetch_buf
   import mfp_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  capture,
   input  logic [DATA_WIDTH-1:0] capture_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output buf_count_t            count
);

   localparam buf_count_t FULL_COUNT = buf_count_t'(PREFETCH_DEPTH);

   logic [DATA_WIDTH-1:0] data0;
   logic [DATA_WIDTH-1:0] data1;

   assign head = data0;

   always_ff @(posedge clk) begin
      if (rst) begin
         data0 <= '0;
         data1 <= '0;
         count <= '0;
      end else begin
         if (pop) begin
            if (count == FULL_COUNT) begin
               data0 <= data1;
               if (capture) data1 <= capture_data;
            end else if (capture) begin
               data0 <= capture_data;
            end
         end else if (capture) begin
            if (count == '0) data0 <= capture_data;
            else             data1 <= capture_data;
         end
         count <= count + {1'b0, capture} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/mfp_ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external dual-port RAM.
// Define MFP_FIFO_LEVEL_EN to add the registered level / almost_full outputs.
module mfp_ram_fifo_ctrl
   import mfp_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  ram_write_enable,
   output logic [ADDR_WIDTH-1:0] ram_write_addr,
   output logic [DATA_WIDTH-1:0] ram_write_data,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   input  logic [DATA_WIDTH-1:0] ram_read_data
`ifdef MFP_FIFO_LEVEL_EN
   ,
   output logic [count_width(ADDR_WIDTH)-1:0] level,
   output logic                               almost_full
`endif
);

   localparam logic [ADDR_WIDTH:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   ram_count;
   logic                  inflight;
   buf_count_t            buf_count;
   logic                  push;
   logic                  pop;
   logic                  fetch;
   logic [2:0]            buf_after_pop;

   assign in_ready  = (ram_count != RAM_DEPTH);
   assign out_valid = (buf_count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Buffer slots committed after this cycle; a new fetch needs one of them free.
   assign buf_after_pop = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
   assign fetch         = (ram_count != '0) && (buf_after_pop < 3'd2);

   assign ram_write_enable = push;
   assign ram_write_addr   = wr_ptr;
   assign ram_write_data   = in_data;
   assign ram_read_addr    = rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_count <= '0;
         inflight  <= 1'b0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (fetch) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         inflight  <= fetch;
         ram_count <= ram_count + {{ADDR_WIDTH{1'b0}}, push}
                                - {{ADDR_WIDTH{1'b0}}, fetch};
      end
   end

   mfp_fifo_prefetch_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_prefetch_buf (
      .clk          (clk),
      .rst          (rst),
      .capture      (inflight),
      .capture_data (ram_read_data),
      .pop          (pop),
      .head         (out_data),
      .count        (buf_count)
   );

`ifdef MFP_FIFO_LEVEL_EN
   localparam int CW = count_width(ADDR_WIDTH);

   logic [CW-1:0] level_next;

   // Words only enter on push and leave on pop, so tracking the delta keeps
   // level equal to ram_count + inflight + buf_count after every edge.
   assign level_next = level + CW'(push) - CW'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         level       <= '0;
         almost_full <= 1'b0;
      end else begin
         level       <= level_next;
         almost_full <= (level_next >= CW'(1 << ADDR_WIDTH));
      end
   end
`endif

endmodule

// File: tb/tb_mfp_ram_fifo_ctrl.sv
// Self-checking bench for mfp_ram_fifo_ctrl with a queue-level FIFO model.
// Builds with or without MFP_FIFO_LEVEL_EN.
module tb_mfp_ram_fifo_ctrl;

   localparam int AW = 3;
   localparam int DW = 32;
   localparam int D  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          ram_write_enable;
   logic [AW-1:0] ram_write_addr;
   logic [DW-1:0] ram_write_data;
   logic [AW-1:0] ram_read_addr;
   logic [DW-1:0] ram_read_data;
`ifdef MFP_FIFO_LEVEL_EN
   logic [AW+1:0] level;
   logic          almost_full;
`endif

   always #5 clk = ~clk;

   mfp_ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .ram_write_enable (ram_write_enable),
      .ram_write_addr   (ram_write_addr),
      .ram_write_data   (ram_write_data),
      .ram_read_addr    (ram_read_addr),
      .ram_read_data    (ram_read_data)
`ifdef MFP_FIFO_LEVEL_EN
      ,
      .level            (level),
      .almost_full      (almost_full)
`endif
   );

   mfp_dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
      .clk          (clk),
      .write_enable (ram_write_enable),
      .write_addr   (ram_write_addr),
      .write_data   (ram_write_data),
      .read_addr    (ram_read_addr),
      .read_data    (ram_read_data)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: words stored in RAM, the word being read back, and the visible buffer.
   logic [DW-1:0] ram_q[$];
   logic [DW-1:0] pipe_q[$];
   logic [DW-1:0] buf_q[$];
   int            wr_idx;
   int            rd_idx;
   logic          m_push, m_pop, m_fetch, exp_ready, exp_valid;
   int            total;

   always @(negedge clk) begin
      if (rst) begin
         ram_q.delete();
         pipe_q.delete();
         buf_q.delete();
         wr_idx = 0;
         rd_idx = 0;
      end else begin
         exp_ready = (ram_q.size() != D);
         exp_valid = (buf_q.size() != 0);
         total     = ram_q.size() + pipe_q.size() + buf_q.size();
         chk("in_ready", in_ready, exp_ready);
         chk("out_valid", out_valid, exp_valid);
         if (exp_valid) chk("out_data", out_data, buf_q[0]);
         m_push = in_valid && exp_ready;
         chk("ram_write_enable", ram_write_enable, m_push);
         if (m_push) begin
            chk("ram_write_addr", ram_write_addr, wr_idx % D);
            chk("ram_write_data", ram_write_data, in_data);
         end
         chk("ram_read_addr", ram_read_addr, rd_idx % D);
`ifdef MFP_FIFO_LEVEL_EN
         chk("level", level, total);
         chk("almost_full", almost_full, total >= D);
`endif
         m_pop   = exp_valid && out_ready;
         m_fetch = (ram_q.size() != 0) && (buf_q.size() + pipe_q.size() - int'(m_pop) < 2);
         if (m_pop) void'(buf_q.pop_front());
         if (pipe_q.size() != 0) buf_q.push_back(pipe_q.pop_front());
         if (m_fetch) begin
            pipe_q.push_back(ram_q.pop_front());
            rd_idx++;
         end
         if (m_push) begin
            ram_q.push_back(in_data);
            wr_idx++;
         end
      end
   end

   task automatic drive(input logic r, input logic iv, input logic [DW-1:0] d, input logic ordy);
      @(posedge clk);
      #1;
      rst       = r;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, '0, 1'b0);
      @(negedge clk);
   endtask

   int w, acc, pops, bubbles, pushed, popped;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ram_we", ram_write_enable, 0);
      chk("rst_out_data", out_data, 0);
`ifdef MFP_FIFO_LEVEL_EN
      chk("rst_level", level, 0);
      chk("rst_almost_full", almost_full, 0);
`endif

      // Single push: visible three cycles later, gone after the pop.
      drive(1'b0, 1'b1, 32'hA5A5_0001, 1'b1);
      @(negedge clk);
      chk("lat_c0_valid", out_valid, 0);
      for (int c = 1; c <= 4; c++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         @(negedge clk);
         if (c == 3) begin
            chk("lat_c3_valid", out_valid, 1);
            chk("lat_c3_data", out_data, 32'hA5A5_0001);
         end else begin
            chk("lat_other_valid", out_valid, 0);
         end
      end

      // Fill: D + 2 words accepted, then back-pressure.
      do_reset();
      w = 0; acc = 0;
      for (int c = 0; c < 16; c++) begin
         drive(1'b0, w < 12, DW'(w), 1'b0);
         @(negedge clk);
         if (in_valid && in_ready) begin
            acc++;
            w++;
         end
      end
      chk("full_accepted", acc, 10);
      chk("full_in_ready", in_ready, 0);
      chk("full_no_write", ram_write_enable, 0);
`ifdef MFP_FIFO_LEVEL_EN
      chk("full_level", level, 10);
      chk("full_almost_full", almost_full, 1);
`endif

      // Drain: ten pops back to back, in order.
      for (int c = 0; c < 12; c++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         @(negedge clk);
         if (c == 0) chk("drain_in_ready_c0", in_ready, 0);
         if (c == 1) chk("drain_in_ready_c1", in_ready, 1);
         if (c < 10) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, c);
         end else begin
            chk("drain_empty", out_valid, 0);
         end
      end

      // Streaming: one push and one pop per cycle after the fill.
      do_reset();
      pops = 0; bubbles = 0; pushed = 0;
      for (int c = 0; c < 1003; c++) begin
         drive(1'b0, pushed < 1000, 32'h1000_0000 + DW'(pushed), 1'b1);
         @(negedge clk);
         if (in_valid && in_ready) pushed++;
         if (c >= 3 && !out_valid) bubbles++;
         if (out_valid) begin
            if (out_data !== 32'h1000_0000 + DW'(pops))
               chk("stream_data", out_data, 32'h1000_0000 + DW'(pops));
            pops++;
         end
      end
      chk("stream_pushed", pushed, 1000);
      chk("stream_pops", pops, 1000);
      chk("stream_bubbles", bubbles, 0);

      // Random handshakes on both sides.
      do_reset();
      pushed = 0; popped = 0;
      for (int c = 0; c < 40000 && popped < 5000; c++) begin
         drive(1'b0, (pushed < 5000) && ($urandom_range(0, 1) == 1), $urandom,
               $urandom_range(0, 1) == 1);
         @(negedge clk);
         if (in_valid && in_ready) pushed++;
         if (out_valid && out_ready) popped++;
      end
      chk("rand_popped", popped, 5000);

      // Reset while words are stored and a read is in flight.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 32'h5000 + DW'(i), 1'b0);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      chk("mid_head", out_data, 32'h5000);
      drive(1'b1, 1'b0, '0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
      @(negedge clk);
      chk("mid_out_valid", out_valid, 0);
      chk("mid_in_ready", in_ready, 1);
`ifdef MFP_FIFO_LEVEL_EN
      chk("mid_level", level, 0);
`endif
      for (int c = 1; c <= 3; c++) begin
         drive(1'b0, 1'b0, '0, 1'b1);
         @(negedge clk);
         if (c == 3) begin
            chk("mid_c3_valid", out_valid, 1);
            chk("mid_c3_data", out_data, 32'hDEAD_BEEF);
         end else begin
            chk("mid_early_valid", out_valid, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
